// File: rtl/accel_tilt_filter.sv
// Tilt-to-speed filter: calibrates a zero offset, then turns accelerometer samples into
// clamped per-axis speeds through a moving average, a deadzone and a shift. Latency is 2 cycles.
module accel_tilt_filter #(
    parameter int AVG_DEPTH   = 4,
    parameter int CAL_SAMPLES = 8,
    parameter int DEADZONE    = 16,
    parameter int SHIFT       = 5,
    parameter int MAX_SPEED   = 4
) (
    input  logic        slowclk,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [15:0] data_x,
    input  logic [15:0] data_y,
    input  logic        recal,
    input  logic        freeze,
    output logic [7:0]  speed_x,
    output logic [7:0]  speed_y,
    output logic        out_valid,
    output logic        calibrated,
    output logic [1:0]  state
);

    localparam int AVG_LG = $clog2(AVG_DEPTH);
    localparam int CAL_LG = $clog2(CAL_SAMPLES);
    localparam int CNT_W  = CAL_LG + 1;
    localparam int FILL_W = AVG_LG + 1;

    localparam logic [1:0] S_CAL = 2'd0;
    localparam logic [1:0] S_RUN = 2'd1;
    localparam logic [1:0] S_FRZ = 2'd2;

    localparam logic signed [18:0] DZ = 19'(DEADZONE);
    localparam logic signed [18:0] MS = 19'(MAX_SPEED);

    logic [1:0]        r_state, w_next;
    logic [CNT_W-1:0]  r_cal_cnt;
    logic [FILL_W-1:0] r_fill;
    logic              r_s1_vld, r_out_vld;
    logic signed [19:0] r_acc [2];
    logic signed [15:0] r_off [2];
    logic signed [15:0] r_s1  [2];
    logic signed [15:0] r_buf [2][AVG_DEPTH];
    logic signed [18:0] r_sum [2];
    logic signed [7:0]  r_spd [2];

    logic signed [15:0] w_data    [2];
    logic signed [19:0] w_acc_nxt [2];
    logic signed [15:0] w_off_nxt [2];
    logic signed [15:0] w_corr    [2];
    logic signed [18:0] w_sum_nxt [2];
    logic signed [7:0]  w_spd     [2];
    logic w_cal_take, w_cal_done, w_accept, w_proc, w_full;

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767)       sat16 = 16'sh7FFF;
        else if (v < -17'sd32768) sat16 = 16'sh8000;
        else                      sat16 = v[15:0];
    endfunction

    // Deadzone is subtracted toward zero before the shift so speed grows smoothly from 0.
    function automatic logic signed [7:0] to_speed(input logic signed [18:0] sum);
        logic signed [18:0] avg, d, s;
        avg = sum >>> AVG_LG;
        if (avg > DZ)       d = avg - DZ;
        else if (avg < -DZ) d = avg + DZ;
        else                d = '0;
        s = d >>> SHIFT;
        if (s > MS)       s = MS;
        else if (s < -MS) s = -MS;
        to_speed = s[7:0];
    endfunction

    assign w_data[0] = data_x;
    assign w_data[1] = data_y;

    assign w_cal_take = (r_state == S_CAL) && sample_valid && !recal;
    assign w_cal_done = w_cal_take && (r_cal_cnt == CNT_W'(CAL_SAMPLES - 1));
    assign w_accept   = (r_state == S_RUN) && sample_valid && !freeze && !recal;
    // A stage-1 sample is dropped if freeze or recal shows up before it reaches the buffer.
    assign w_proc     = r_s1_vld && (r_state == S_RUN) && !freeze && !recal;
    assign w_full     = (r_fill >= FILL_W'(AVG_DEPTH - 1));

    for (genvar a = 0; a < 2; a++) begin : g_ax
        assign w_acc_nxt[a] = r_acc[a] + 20'(w_data[a]);
        assign w_off_nxt[a] = 16'(w_acc_nxt[a] >>> CAL_LG);
        assign w_corr[a]    = sat16(17'(w_data[a]) - 17'(r_off[a]));
        assign w_sum_nxt[a] = r_sum[a] + 19'(r_s1[a]) - 19'(r_buf[a][AVG_DEPTH-1]);
        assign w_spd[a]     = to_speed(w_sum_nxt[a]);
    end

    always_ff @(posedge slowclk or negedge reset_n) begin
        if (!reset_n) r_state <= S_CAL;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (recal) begin
            w_next = S_CAL;
        end else begin
            case (r_state)
                S_CAL:   if (w_cal_done) w_next = S_RUN;
                S_RUN:   if (freeze)     w_next = S_FRZ;
                S_FRZ:   if (!freeze)    w_next = S_RUN;
                default: w_next = S_CAL;
            endcase
        end
    end

    always_comb begin
        state      = r_state;
        calibrated = (r_state == S_RUN) || (r_state == S_FRZ);
    end

    always_ff @(posedge slowclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cal_cnt <= '0;
            for (int a = 0; a < 2; a++) begin
                r_acc[a] <= '0;
                r_off[a] <= '0;
            end
        end else if (recal || w_cal_done) begin
            r_cal_cnt <= '0;
            for (int a = 0; a < 2; a++) begin
                r_acc[a] <= '0;
                if (w_cal_done) r_off[a] <= w_off_nxt[a];
            end
        end else if (w_cal_take) begin
            r_cal_cnt <= r_cal_cnt + 1'b1;
            for (int a = 0; a < 2; a++) r_acc[a] <= w_acc_nxt[a];
        end
    end

    always_ff @(posedge slowclk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld <= 1'b0;
            for (int a = 0; a < 2; a++) r_s1[a] <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) for (int a = 0; a < 2; a++) r_s1[a] <= w_corr[a];
        end
    end

    always_ff @(posedge slowclk or negedge reset_n) begin
        if (!reset_n) begin
            r_fill <= '0;
            for (int a = 0; a < 2; a++) begin
                r_sum[a] <= '0;
                for (int i = 0; i < AVG_DEPTH; i++) r_buf[a][i] <= '0;
            end
        end else if (w_cal_done) begin
            r_fill <= '0;
            for (int a = 0; a < 2; a++) begin
                r_sum[a] <= '0;
                for (int i = 0; i < AVG_DEPTH; i++) r_buf[a][i] <= '0;
            end
        end else if (w_proc) begin
            if (r_fill != FILL_W'(AVG_DEPTH)) r_fill <= r_fill + 1'b1;
            for (int a = 0; a < 2; a++) begin
                r_sum[a]    <= w_sum_nxt[a];
                r_buf[a][0] <= r_s1[a];
                for (int i = 1; i < AVG_DEPTH; i++) r_buf[a][i] <= r_buf[a][i-1];
            end
        end
    end

    always_ff @(posedge slowclk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_vld <= 1'b0;
            for (int a = 0; a < 2; a++) r_spd[a] <= '0;
        end else begin
            r_out_vld <= w_proc && w_full;
            if (recal)                for (int a = 0; a < 2; a++) r_spd[a] <= '0;
            else if (w_proc && w_full) for (int a = 0; a < 2; a++) r_spd[a] <= w_spd[a];
        end
    end

    assign speed_x   = r_spd[0];
    assign speed_y   = r_spd[1];
    assign out_valid = r_out_vld;

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Bench for accel_tilt_filter: directed vector table, freeze/recal sequences, and a randomized
// phase checked against a queue-based moving-average model.
module tb_accel_tilt_filter;
    localparam int DEPTH = 4;

    logic        slowclk = 1'b0, reset_n = 1'b0, sample_valid = 1'b0, recal = 1'b0, freeze = 1'b0;
    logic [15:0] data_x = '0, data_y = '0;
    logic [7:0]  speed_x, speed_y;
    logic        out_valid, calibrated;
    logic [1:0]  state;
    int total = 0, bad = 0;

    typedef struct { int x; int y; int ev; int sx; int sy; } vec_t;
    vec_t tbl[$];
    int qx[$], qy[$];
    int offx, offy, m_sx, m_sy;
    int cx[8], cy[8];

    always #5 slowclk = ~slowclk;

    accel_tilt_filter dut (
        .slowclk(slowclk), .reset_n(reset_n), .sample_valid(sample_valid),
        .data_x(data_x), .data_y(data_y), .recal(recal), .freeze(freeze),
        .speed_x(speed_x), .speed_y(speed_y), .out_valid(out_valid),
        .calibrated(calibrated), .state(state)
    );

    task automatic step();
        @(posedge slowclk); #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int ev, input int sx, input int sy);
        chk({nm, ".valid"}, int'(out_valid), ev);
        chk({nm, ".sx"}, int'($signed(speed_x)), sx);
        chk({nm, ".sy"}, int'($signed(speed_y)), sy);
    endtask

    task automatic send(input int x, input int y);
        sample_valid = 1'b1; data_x = 16'(x); data_y = 16'(y);
        step();
        sample_valid = 1'b0;
        step();
    endtask

    task automatic calib(input string nm);
        for (int i = 0; i < 8; i++) begin
            sample_valid = 1'b1; data_x = 16'(cx[i]); data_y = 16'(cy[i]);
            step();
            if (i == 6) begin
                chk({nm, ".state7"}, int'(state), 0);
                chk({nm, ".cal7"}, int'(calibrated), 0);
            end
        end
        sample_valid = 1'b0;
        chk({nm, ".state8"}, int'(state), 1);
        chk({nm, ".cal8"}, int'(calibrated), 1);
    endtask

    task automatic add(input int x, input int y, input int ev, input int sx, input int sy);
        vec_t v;
        v.x = x; v.y = y; v.ev = ev; v.sx = sx; v.sy = sy;
        tbl.push_back(v);
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int spd(input int avg);
        int d;
        if (avg >= -16 && avg <= 16) return 0;
        d = (avg > 0) ? avg - 16 : avg + 16;
        return clampi(fdiv(d, 32), -4, 4);
    endfunction

    function automatic int qsum(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic model_push(input int x, input int y, output int ev, output int sx, output int sy);
        qx.push_back(clampi(x - offx, -32768, 32767));
        qy.push_back(clampi(y - offy, -32768, 32767));
        if (qx.size() > DEPTH) begin void'(qx.pop_front()); void'(qy.pop_front()); end
        ev = (qx.size() == DEPTH) ? 1 : 0;
        if (ev == 1) begin
            m_sx = spd(fdiv(qsum(qx), DEPTH));
            m_sy = spd(fdiv(qsum(qy), DEPTH));
        end
        sx = m_sx; sy = m_sy;
    endtask

    function automatic int rnd_data(input int off);
        logic [15:0] rr;
        rr = 16'($urandom);
        if ($urandom_range(0, 9) == 0) return int'($signed(rr));
        return off + int'($urandom_range(0, 1200)) - 600;
    endfunction

    initial begin
        int e1v, e1x, e1y, e2v, e2x, e2y, x1, y1, x2, y2, sx, sy;

        for (int i = 0; i < 4; i++) add(100, -40, (i == 3) ? 1 : 0, 0, 0);
        add(180, -40, 1, 0, 0);   add(180, -40, 1, 0, 0);   add(180, -40, 1, 1, 0);   add(180, -40, 1, 2, 0);
        add(20, -40, 1, 0, 0);    add(20, -40, 1, 0, 0);    add(20, -40, 1, -1, 0);   add(20, -40, 1, -2, 0);
        add(436, -240, 1, 0, -2); add(436, -240, 1, 3, -3); add(436, -240, 1, 4, -4); add(436, -240, 1, 4, -4);
        add(180, -40, 1, 4, -4);  add(180, -40, 1, 4, -3);  add(180, -40, 1, 4, -2);  add(180, -40, 1, 2, 0);
        add(436, -40, 1, 4, 0);
        for (int i = 0; i < 4; i++) add(-32768, 32767, 1, -4, 4);

        step(); step();
        chk("rst.state", int'(state), 0);
        chk("rst.cal", int'(calibrated), 0);
        chk_out("rst", 0, 0, 0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin cx[i] = 100; cy[i] = -40; end
        calib("cal1");
        chk_out("cal1.out", 0, 0, 0);

        foreach (tbl[i])
            begin
                send(tbl[i].x, tbl[i].y);
                chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].sx, tbl[i].sy);
            end

        freeze = 1'b1;
        step();
        chk("frz.state", int'(state), 2);
        for (int i = 0; i < 3; i++) begin
            send(436, -240);
            chk_out($sformatf("frz%0d", i), 0, -4, 4);
        end
        chk("frz.cal", int'(calibrated), 1);
        freeze = 1'b0;
        step();
        chk("unfrz.state", int'(state), 1);
        send(180, -40);
        chk_out("unfrz", 1, -4, 4);

        sample_valid = 1'b1; data_x = 16'(436); data_y = 16'(-40);
        step();
        sample_valid = 1'b0; freeze = 1'b1;
        step();
        chk_out("inflight", 0, -4, 4);
        freeze = 1'b0;
        step();

        recal = 1'b1; sample_valid = 1'b1; data_x = 16'(500); data_y = 16'(500);
        step();
        recal = 1'b0; sample_valid = 1'b0;
        chk("recal.state", int'(state), 0);
        chk("recal.cal", int'(calibrated), 0);
        chk_out("recal", 0, 0, 0);

        begin
            int s0 = 0, s1 = 0;
            for (int i = 0; i < 8; i++) begin
                cx[i] = int'($urandom_range(0, 4000)) - 2000;
                cy[i] = int'($urandom_range(0, 4000)) - 2000;
                s0 += cx[i]; s1 += cy[i];
            end
            offx = fdiv(s0, 8); offy = fdiv(s1, 8);
        end
        calib("cal2");
        qx.delete(); qy.delete(); m_sx = 0; m_sy = 0;

        for (int n = 0; n < 50; n++) begin
            x1 = rnd_data(offx); y1 = rnd_data(offy);
            model_push(x1, y1, e1v, e1x, e1y);
            if ($urandom_range(0, 3) == 0) begin
                x2 = rnd_data(offx); y2 = rnd_data(offy);
                model_push(x2, y2, e2v, e2x, e2y);
                sample_valid = 1'b1; data_x = 16'(x1); data_y = 16'(y1);
                step();
                data_x = 16'(x2); data_y = 16'(y2);
                step();
                sample_valid = 1'b0;
                chk_out($sformatf("rpa%0d", n), e1v, e1x, e1y);
                step();
                chk_out($sformatf("rpb%0d", n), e2v, e2x, e2y);
            end else begin
                send(x1, y1);
                chk_out($sformatf("rnd%0d", n), e1v, e1x, e1y);
            end
        end

        sx = m_sx; sy = m_sy;
        step();
        chk_out("idle", 0, sx, sy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/accel_tilt_filter.md
ACCEL_TILT_FILTER -- requirements
Module: accel_tilt_filter

Interface
REQ-001 Parameter AVG_DEPTH, default 4, moving-average depth per axis (power of two, 2..8).
REQ-002 Parameter CAL_SAMPLES, default 8, samples averaged for zero-offset calibration (power of two).
REQ-003 Parameter DEADZONE, default 16, magnitude at or below which averaged tilt maps to zero speed.
REQ-004 Parameter SHIFT, default 5, arithmetic right-shift applied after deadzone removal.
REQ-005 Parameter MAX_SPEED, default 4, symmetric saturation limit for speed outputs.
REQ-006 slowclk  in  1  block clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 sample_valid  in  1  one-cycle strobe: data_x/data_y hold a new accelerometer sample.
REQ-009 data_x, data_y  in  16 each  signed two's-complement raw accelerometer readings.
REQ-010 recal  in  1  level; forces recalibration.
REQ-011 freeze  in  1  level; holds outputs and ignores samples.
REQ-012 speed_x, speed_y  out  8 each  signed per-frame spaceship displacement, range -MAX_SPEED..+MAX_SPEED.
REQ-013 out_valid  out  1  one-cycle pulse when speed_x/speed_y update.
REQ-014 calibrated  out  1  high when offsets are valid (state RUN or FREEZE).
REQ-015 state  out  2  current FSM state: CAL=0, RUN=1, FREEZE=2.

Function
REQ-016 The FSM SHALL leave CAL for RUN on the cycle after the CAL_SAMPLES-th accepted sample.
REQ-017 RUN SHALL go to FREEZE when freeze=1 and FREEZE SHALL return to RUN when freeze=0, preserving buffers and offsets.
REQ-018 recal=1 SHALL force CAL next cycle from any state, with priority over freeze and over a coincident sample_valid (sample discarded).
REQ-019 In CAL, each sample_valid SHALL add data to per-axis 20-bit signed accumulators; on completion offset = accumulator >>> log2(CAL_SAMPLES) (arithmetic), and accumulators, averaging buffers, sums and fill count SHALL clear.
REQ-020 In RUN, each sample_valid SHALL compute corrected = data - offset in 17 bits, saturated to -32768..32767.
REQ-021 The corrected value SHALL be pushed into an AVG_DEPTH-deep per-axis shift buffer with running sum updated as sum + new - oldest (19-bit signed).
REQ-022 avg = sum >>> log2(AVG_DEPTH), arithmetic.
REQ-023 |avg| <= DEADZONE SHALL yield speed 0; otherwise speed = (avg - sign(avg)*DEADZONE) >>> SHIFT, clamped to ±MAX_SPEED.
REQ-024 Latency SHALL be exactly 2 cycles: sample_valid at cycle N -> speed_x/speed_y and out_valid=1 at cycle N+2.
REQ-025 out_valid SHALL not pulse, and speeds SHALL stay 0, until AVG_DEPTH corrected samples have entered the buffer since the last calibration.
REQ-026 In CAL, speeds SHALL be 0 and out_valid 0; in FREEZE, speeds SHALL hold last values, out_valid 0, and samples SHALL be ignored.
REQ-027 A sample in flight (stage 1) when freeze or recal asserts SHALL be dropped with no out_valid.
REQ-028 Back-to-back sample_valid on consecutive cycles SHALL each be accepted and produce consecutive out_valid pulses.

Reset
REQ-029 While reset_n=0: state=CAL, calibrated=0, speed_x=speed_y=0, out_valid=0, offsets, accumulators, buffers, sums and counters =0.
REQ-030 Reset assertion mid-calibration or mid-pipeline SHALL discard all partial data; after release, a full CAL_SAMPLES calibration SHALL be required.

Verification
REQ-031 Reset, 8 samples x=100,y=-40 -> calibrated=1 and state=RUN on cycle after 8th sample; offsets 100/-40.
REQ-032 After REQ-031, 4 samples x=100,y=-40 -> first out_valid 2 cycles after 4th sample, speed_x=speed_y=0.
REQ-033 Steady x=180 (avg 80) -> speed_x=2; x=20 (avg -80) -> speed_x=-2; x=436 (avg 336) -> speed_x=4 (clamped).
REQ-034 Settled at x=180, one sample x=436 -> avg 144, speed_x=4 on that sample's out_valid; data_x=-32768 stream -> speed_x=-4, no wrap.
REQ-035 freeze=1 while 3 samples arrive -> no out_valid, speeds held, state=2; freeze=0 -> next sample updates with preserved buffer.
REQ-036 recal pulsed in RUN coincident with sample_valid -> state=CAL next cycle, calibrated=0, speeds 0, sample discarded, 8 new samples required.
